// File: rtl/bidir_bus_arbiter_pkg.sv
// Shared definitions for the bidirectional bus arbiter and the pad-level
// logic around it: FSM state encodings and the owner-index width helper.
package bidir_bus_arbiter_pkg;

    // Arbiter states; pad-level modules decode these directly.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // Width of an owner index; never narrower than one bit.
    function automatic int ow_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bidir_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request at or
// after the start index, wrapping past the top back to requester 0.
module bidir_bus_arbiter_rr_pick
    import bidir_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int OW    = ow_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    start,
    output logic             valid,
    output logic [OW-1:0]    winner,
    output logic [N_REQ-1:0] winner_onehot
);

    // Scan farthest-to-nearest so the requester closest to start wins.
    always_comb begin
        int          pos;
        logic [OW-1:0] pos_idx;
        valid         = 1'b0;
        winner        = '0;
        winner_onehot = '0;
        pos           = 0;
        pos_idx       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = int'(start) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = OW'(pos);
            if (req[pos_idx]) begin
                valid                  = 1'b1;
                winner                 = pos_idx;
                winner_onehot          = '0;
                winner_onehot[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bidir_bus_arbiter.sv
// Round-robin owner arbiter for one shared tristate line. Grants the line,
// drives the pad output enable, inserts a high-Z turnaround between owners
// and forces release after MAX_HOLD cycles of continuous ownership.
module bidir_bus_arbiter
    import bidir_bus_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            done,
    output logic [N_REQ-1:0]            grant,
    output logic [ow_width(N_REQ)-1:0]  owner,
    output logic                        output_enable,
    output logic                        busy,
    output logic                        timeout
);

    localparam int OW = ow_width(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

    arb_state_e        state;
    logic [HW-1:0]     hold_cnt;
    logic [TW-1:0]     turn_cnt;

    logic [OW-1:0]     rr_start;
    logic              pick_valid;
    logic [OW-1:0]     pick_idx;
    logic [N_REQ-1:0]  pick_onehot;

    logic [HW-1:0]     hold_nxt;
    logic              hold_limit;
    logic              release_now;
    logic              turn_last;

    // Search begins just past the last owner so it gets lowest priority.
    assign rr_start = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    bidir_bus_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .OW    (OW)
    ) u_rr_pick (
        .req           (req),
        .start         (rr_start),
        .valid         (pick_valid),
        .winner        (pick_idx),
        .winner_onehot (pick_onehot)
    );

    // Release when the owner is done, stops requesting, or hits the hold cap.
    always_comb begin
        hold_nxt    = hold_cnt + 1'b1;
        hold_limit  = (hold_nxt == HOLD_MAX);
        release_now = done[owner] | ~req[owner] | hold_limit;
        turn_last   = (turn_cnt == TURN_LAST);
    end

    // Ownership FSM; every output is a flop so the pad enable cannot glitch
    // and reset removes the drive immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            owner         <= LAST_IDX;
            output_enable <= 1'b0;
            busy          <= 1'b0;
            timeout       <= 1'b0;
            hold_cnt      <= '0;
            turn_cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state         <= GRANT;
                        grant         <= pick_onehot;
                        owner         <= pick_idx;
                        output_enable <= 1'b1;
                        busy          <= 1'b1;
                        hold_cnt      <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state         <= TURN;
                        grant         <= '0;
                        output_enable <= 1'b0;
                        busy          <= 1'b1;
                        turn_cnt      <= '0;
                        timeout       <= hold_limit;
                    end else begin
                        hold_cnt <= hold_nxt;
                    end
                end
                TURN: begin
                    if (turn_last) begin
                        if (pick_valid) begin
                            state         <= GRANT;
                            grant         <= pick_onehot;
                            owner         <= pick_idx;
                            output_enable <= 1'b1;
                            busy          <= 1'b1;
                            hold_cnt      <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    grant         <= '0;
                    output_enable <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
